envelope_trigger: RTL and testbench
===================================

Name: envelope_trigger

Overview:
- Upstream stage of the modulator. Conditions the raw envelope-detector comparator output (asynchronous, noisy) into a clean trigger_signal.
- trigger_signal asserts once an excitation packet is confirmed present and deasserts at packet end.
- Filters glitches, bridges short intra-packet dropouts, enforces a maximum packet length, and applies a re-arm holdoff.
- Runs on the 10 MHz system clock, so 1 cycle = 100 ns.

Parameters:
GLITCH_CYCLES, 3, consecutive cycles a synchronized level must be stable before the filtered level follows it (range 1..15)
QUALIFY_CYCLES, 200, consecutive filtered-high cycles required before trigger asserts (20 us)
GAP_CYCLES, 50, maximum filtered-low run tolerated inside a packet without ending it (5 us)
MAX_ACTIVE_CYCLES, 20000, cap on cycles trigger may stay high (2 ms)
HOLDOFF_CYCLES, 500, minimum trigger-low time before re-arming (50 us)
CNT_W, 16, counter width; must hold max(QUALIFY, GAP, MAX_ACTIVE, HOLDOFF)

Ports:
clock  input  1  system clock, 10 MHz, rising edge
reset  input  1  asynchronous, active-low reset
envelope_in  input  1  raw comparator output, asynchronous to clock
trigger_signal  output  1  registered; high while a qualified packet is present; drives modulator trigger_signal
busy  output  1  registered; high in every state except IDLE
timeout_pulse  output  1  registered; one-cycle pulse when MAX_ACTIVE_CYCLES forces trigger low
packet_count  output  8  registered; count of trigger rising edges, wraps 255->0

Behaviour:
- Reset (reset=0, asynchronous): synchronizer flops, filtered level, all counters and all outputs go to 0; FSM goes to IDLE. Reset asserted mid-packet drops trigger_signal immediately with no timeout_pulse.
- Synchronizer: two flops, env_sync, no reset-release glitch.
- Glitch filter:
  - env_filt takes env_sync once env_sync has differed from env_filt for GLITCH_CYCLES consecutive cycles.
  - Any agreeing cycle clears the run counter.
- End-to-end latency, envelope_in edge to env_filt edge: 2+GLITCH_CYCLES clocks (5 at defaults).
- FSM states: IDLE, QUALIFY, ACTIVE, GAP, HOLDOFF. One counter is shared by QUALIFY/GAP/HOLDOFF. A separate act_cnt runs through ACTIVE+GAP.
- IDLE:
  - trigger=0.
  - env_filt=1: go to QUALIFY, cnt=1.
- QUALIFY:
  - env_filt=0: go to IDLE, no output change.
  - env_filt=1 and cnt=QUALIFY_CYCLES: go to ACTIVE. Set trigger=1, act_cnt=0, packet_count+1 on that same edge.
  - Otherwise cnt+1.
- Trigger rise: exactly 2+GLITCH_CYCLES+QUALIFY_CYCLES clocks after the first edge sampling envelope_in high (205 at defaults).
- ACTIVE:
  - trigger=1.
  - env_filt=0: go to GAP, cnt=1.
- GAP:
  - trigger stays 1.
  - env_filt=1: return to ACTIVE.
  - cnt=GAP_CYCLES: go to HOLDOFF, trigger=0.
  - Otherwise cnt+1.
- Trigger fall on a normal end: 2+GLITCH_CYCLES+GAP_CYCLES clocks after envelope_in falls (55 at defaults).
- act_cnt:
  - Increments every cycle in ACTIVE and GAP.
  - On reaching MAX_ACTIVE_CYCLES-1: go to HOLDOFF, trigger=0, timeout_pulse=1 for one cycle.
  - Timeout has priority over GAP exit on the same cycle; timeout_pulse still fires.
- HOLDOFF:
  - trigger=0. Counts HOLDOFF_CYCLES.
  - On expiry: go to IDLE only if env_filt=0; otherwise wait in HOLDOFF until env_filt=0. This blocks re-triggering on a timed-out packet.
- Any env_filt=1 run shorter than QUALIFY_CYCLES never produces a trigger.
- busy=1 in every state except IDLE.
- Counters saturate, never wrap. packet_count is the only wrapping counter.

Test Plan:
1. Reset held 1 us, envelope_in=1 throughout -> all outputs 0. After release: trigger rises at cycle 205; packet_count=1; busy rises at cycle 6.
2. 2-cycle envelope_in glitches every 20 cycles for 500 cycles -> env_filt never rises; trigger=0, busy=0.
3. Envelope high 400 cycles, low 30 cycles, high 300 cycles, then low -> one trigger pulse covering the 30-cycle dropout. Trigger falls 55 cycles after the final fall; packet_count=1.
4. Envelope high 150 cycles, then low -> QUALIFY aborts, trigger never rises, busy returns to 0.
5. Envelope high 25000 cycles -> trigger high exactly 20000 cycles; timeout_pulse=1 for one cycle. After that, no retrigger until envelope drops. A new 300-cycle envelope burst after a 600-cycle low gives packet_count=2.
6. Drive reset low mid-ACTIVE -> trigger, busy and packet_count go to 0 asynchronously, no timeout_pulse. After release with envelope high, trigger rises 205 cycles later.

Source files
------------

// File: rtl/envelope_trigger.sv
// Envelope trigger: synchronizes and deglitches the envelope comparator,
// then qualifies packets into a clean trigger with gap bridging and a holdoff.
module envelope_trigger #(
  parameter int GLITCH_CYCLES     = 3,
  parameter int QUALIFY_CYCLES    = 200,
  parameter int GAP_CYCLES        = 50,
  parameter int MAX_ACTIVE_CYCLES = 20000,
  parameter int HOLDOFF_CYCLES    = 500,
  parameter int CNT_W             = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       envelope_in,
  output logic       trigger_signal,
  output logic       busy,
  output logic       timeout_pulse,
  output logic [7:0] packet_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUAL,
    S_ACT,
    S_GAP,
    S_HOLD
  } state_t;

  localparam logic [3:0] GL_LAST =
    4'(GLITCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] Q_LAST =
    CNT_W'(QUALIFY_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_LAST =
    CNT_W'(MAX_ACTIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_N =
    CNT_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             filt_q;
  logic             filt_d;
  logic [3:0]       run_q;
  logic [3:0]       run_d;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] act_q;
  logic [CNT_W-1:0] act_d;
  logic             trig_q;
  logic             trig_d;
  logic             busy_q;
  logic             busy_d;
  logic             to_q;
  logic             to_d;
  logic [7:0]       pc_q;
  logic [7:0]       pc_d;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + ONE;
  endfunction

  // Two-flop synchronizer for the asynchronous comparator output
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= envelope_in;
      sync2_q <= sync1_q;
    end
  end

  // Filtered level follows sync only after a full run of disagreement
  always_comb begin
    filt_d = filt_q;
    run_d  = 4'd0;
    if (sync2_q != filt_q) begin
      if (run_q == GL_LAST) begin
        filt_d = sync2_q;
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  // Glitch filter state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
      run_q  <= 4'd0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  // Packet FSM next state, counters and registered output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    trig_d  = trig_q;
    to_d    = 1'b0;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: begin
        trig_d = 1'b0;
        if (filt_q) begin
          state_d = S_QUAL;
          cnt_d   = ONE;
        end
      end
      S_QUAL: begin
        if (!filt_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == Q_LAST) begin
          state_d = S_ACT;
          trig_d  = 1'b1;
          act_d   = '0;
          cnt_d   = '0;
          pc_d    = pc_q + 8'd1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_ACT, S_GAP: begin
        if (act_q == MAX_LAST) begin
          state_d = S_HOLD;
          trig_d  = 1'b0;
          to_d    = 1'b1;
          cnt_d   = ONE;
        end else begin
          act_d = sat_inc(act_q);
          if (state_q == S_ACT) begin
            if (!filt_q) begin
              state_d = S_GAP;
              cnt_d   = ONE;
            end
          end else if (filt_q) begin
            state_d = S_ACT;
          end else if (cnt_q == GAP_LAST) begin
            state_d = S_HOLD;
            trig_d  = 1'b0;
            cnt_d   = ONE;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      S_HOLD: begin
        trig_d = 1'b0;
        if (cnt_q >= HOLD_N) begin
          if (!filt_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = S_IDLE;
        trig_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // FSM and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      act_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      pc_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      pc_q    <= pc_d;
    end
  end

  assign trigger_signal = trig_q;
  assign busy           = busy_q;
  assign timeout_pulse  = to_q;
  assign packet_count   = pc_q;

endmodule

// File: tb/tb_envelope_trigger.sv
// Bench for envelope_trigger: vector table, directed packet scenarios
// and random envelope bursts against a run-length reference model.
`timescale 1ns/1ps
module tb_envelope_trigger;

  localparam int G  = 3;
  localparam int Q  = 200;
  localparam int GP = 50;
  localparam int MX = 20000;
  localparam int H  = 500;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       envelope_in = 1'b0;
  logic       trigger_signal;
  logic       busy;
  logic       timeout_pulse;
  logic [7:0] packet_count;

  int tests_run = 0;
  int tests_failed = 0;

  envelope_trigger #(
    .GLITCH_CYCLES    (G),
    .QUALIFY_CYCLES   (Q),
    .GAP_CYCLES       (GP),
    .MAX_ACTIVE_CYCLES(MX),
    .HOLDOFF_CYCLES   (H),
    .CNT_W            (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .envelope_in   (envelope_in),
    .trigger_signal(trigger_signal),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .packet_count  (packet_count)
  );

  always #50 clock = ~clock;

  // reference model: pipeline delay, last-G-samples filter, run lengths
  bit   m_s1, m_s2, m_filt;
  bit   m_hist[$];
  bit   m_trig, m_holding, m_to;
  int   m_act, m_lo, m_hold, m_qual, m_pc;

  // observation of DUT transitions
  int   cyc = 0;
  bit   prev_trig = 0;
  int   n_rise = 0, n_fall = 0, n_to = 0;
  int   rise_cyc = 0, fall_cyc = 0, to_cyc = 0;
  string phase = "reset";

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_filt = 0;
    m_hist.delete();
    m_trig = 0; m_holding = 0; m_to = 0;
    m_act = 0; m_lo = 0; m_hold = 0; m_qual = 0; m_pc = 0;
  endtask

  task automatic model_step();
    bit f, sy, all_diff;
    f = m_filt;
    sy = m_s2;
    m_hist.push_back(sy);
    if (m_hist.size() > G) void'(m_hist.pop_front());
    all_diff = (m_hist.size() == G);
    foreach (m_hist[i]) if (m_hist[i] == m_filt) all_diff = 0;
    if (all_diff) m_filt = sy;
    m_to = 0;
    if (m_trig) begin
      if (m_act == MX - 1) begin
        m_trig = 0; m_to = 1; m_holding = 1; m_hold = 0;
      end else begin
        m_act++;
        if (f) m_lo = 0;
        else begin
          m_lo++;
          if (m_lo == GP) begin
            m_trig = 0; m_holding = 1; m_hold = 0;
          end
        end
      end
    end else if (m_holding) begin
      if (m_hold < H) m_hold++;
      if (m_hold >= H && !f) m_holding = 0;
    end else if (f) begin
      m_qual++;
      if (m_qual == Q) begin
        m_trig = 1; m_act = 0; m_lo = 0; m_qual = 0;
        m_pc = (m_pc + 1) % 256;
      end
    end else begin
      m_qual = 0;
    end
    m_s2 = m_s1;
    m_s1 = envelope_in;
  endtask

  task automatic check_model();
    logic [10:0] got, exp;
    got = {trigger_signal, busy, timeout_pulse, packet_count};
    exp = {m_trig, m_trig || m_holding || (m_qual > 0), m_to, 8'(m_pc)};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL model_%s cyc %0d: got trig/busy/to/pc=%b/%b/%b/%0d required %b/%b/%b/%0d",
               phase, cyc, got[10], got[9], got[8], got[7:0],
               exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic expect_int(string name, int got, int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (reset) model_step();
    else model_reset();
    cyc++;
    check_model();
    if (trigger_signal && !prev_trig) begin n_rise++; rise_cyc = cyc; end
    if (!trigger_signal && prev_trig) begin n_fall++; fall_cyc = cyc; end
    if (timeout_pulse) begin n_to++; to_cyc = cyc; end
    prev_trig = trigger_signal;
  endtask

  task automatic apply(int n, bit v);
    envelope_in = v;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  typedef struct {
    int hi;
    int exp_rise;
    int exp_fall;
  } vec_t;

  vec_t vt[7];

  initial begin
    int t0, r0, f0, to0, pc0, busy_c, trig_c, seen;
    vt[0] = '{2, 0, 0};
    vt[1] = '{3, 0, 0};
    vt[2] = '{150, 0, 0};
    vt[3] = '{199, 0, 0};
    vt[4] = '{200, 205, 55};
    vt[5] = '{201, 205, 55};
    vt[6] = '{400, 205, 55};
    model_reset();

    // 1: reset held 1 us with envelope high
    phase = "reset";
    envelope_in = 1'b1;
    repeat (10) tick();
    expect_int("reset_outputs",
               {trigger_signal, busy, timeout_pulse, packet_count}, 0);
    reset = 1'b1;
    busy_c = -1; trig_c = -1;
    phase = "post_reset";
    for (int c = 1; c <= 260; c++) begin
      tick();
      if (busy && busy_c < 0) busy_c = c;
      if (trigger_signal && trig_c < 0) trig_c = c;
    end
    expect_int("busy_rise_cycle", busy_c, 6);
    expect_int("trig_rise_cycle", trig_c, 205);
    expect_int("pc_after_first", packet_count, 1);
    apply(700, 0);

    // vector table: single bursts of varying length
    phase = "table";
    foreach (vt[i]) begin
      r0 = n_rise; f0 = n_fall; pc0 = packet_count;
      t0 = cyc + 1;
      apply(vt[i].hi, 1);
      apply(700, 0);
      expect_int($sformatf("tbl%0d_rises", i), n_rise - r0,
                 vt[i].exp_rise > 0 ? 1 : 0);
      expect_int($sformatf("tbl%0d_pc", i),
                 (packet_count - pc0) & 8'hff,
                 vt[i].exp_rise > 0 ? 1 : 0);
      if (vt[i].exp_rise > 0) begin
        expect_int($sformatf("tbl%0d_rise_at", i),
                   rise_cyc - t0 + 1, vt[i].exp_rise);
        expect_int($sformatf("tbl%0d_fall_at", i),
                   fall_cyc - (t0 + vt[i].hi) + 1, vt[i].exp_fall);
        expect_int($sformatf("tbl%0d_falls", i), n_fall - f0, 1);
      end
    end

    // 2: short glitches never pass the filter
    phase = "glitch";
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      envelope_in = 1'b1;
      repeat (2) begin tick(); if (busy || trigger_signal) seen++; end
      envelope_in = 1'b0;
      repeat (18) begin tick(); if (busy || trigger_signal) seen++; end
    end
    expect_int("glitch_busy_or_trig_cycles", seen, 0);

    // 3: dropout shorter than the gap is bridged
    phase = "dropout";
    r0 = n_rise; pc0 = packet_count;
    t0 = cyc + 1;
    apply(400, 1);
    apply(30, 0);
    apply(300, 1);
    f0 = cyc + 1;
    apply(700, 0);
    expect_int("dropout_rises", n_rise - r0, 1);
    expect_int("dropout_rise_at", rise_cyc - t0 + 1, 205);
    expect_int("dropout_fall_at", fall_cyc - f0 + 1, 55);
    expect_int("dropout_pc", (packet_count - pc0) & 8'hff, 1);

    // 4: burst too short to qualify
    phase = "abort";
    r0 = n_rise; seen = 0;
    envelope_in = 1'b1;
    repeat (150) begin tick(); if (busy) seen = 1; end
    apply(100, 0);
    expect_int("abort_busy_seen", seen, 1);
    expect_int("abort_rises", n_rise - r0, 0);
    expect_int("abort_busy_end", busy, 0);

    // 5: maximum active length and holdoff until envelope drops
    phase = "timeout";
    do_reset();
    r0 = n_rise; to0 = n_to;
    t0 = cyc + 1;
    apply(25000, 1);
    expect_int("to_rise_at", rise_cyc - t0 + 1, 205);
    expect_int("to_high_len", fall_cyc - rise_cyc, MX);
    expect_int("to_pulse_cycles", n_to - to0, 1);
    expect_int("to_pulse_at_fall", to_cyc, fall_cyc);
    expect_int("to_no_retrigger", n_rise - r0, 1);
    apply(600, 0);
    apply(300, 1);
    apply(700, 0);
    expect_int("to_pc_final", packet_count, 2);

    // 6: asynchronous reset in the middle of a packet
    phase = "async_reset";
    to0 = n_to;
    apply(300, 1);
    expect_int("ar_trig_before", trigger_signal, 1);
    #20;
    reset = 1'b0;
    #1;
    model_reset();
    expect_int("ar_outputs_async",
               {trigger_signal, busy, timeout_pulse, packet_count}, 0);
    prev_trig = 0;
    repeat (5) tick();
    reset = 1'b1;
    r0 = n_rise;
    t0 = cyc + 1;
    repeat (260) tick();
    expect_int("ar_rises", n_rise - r0, 1);
    expect_int("ar_rise_at", rise_cyc - t0 + 1, 205);
    expect_int("ar_no_timeout", n_to - to0, 0);
    apply(700, 0);

    // random bursts checked cycle by cycle against the model
    phase = "random";
    for (int k = 0; k < 40; k++) begin
      apply($urandom_range(450, 1), 1);
      if ($urandom_range(3, 0) == 0) apply($urandom_range(700, 400), 0);
      else apply($urandom_range(120, 1), 0);
    end
    apply(700, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
